digit_scan_mux: RTL and testbench
=================================

Name: digit_scan_mux

Overview:
- Parametrised, time-multiplexed digit scanner for multi-digit displays.
- Snapshots a packed word of DIGITS fields, each DW bits wide.
- Cycles a one-hot select across the digits at a programmable slot rate and presents the selected field on a shared bus.
- Adds a ghost-suppression guard interval, per-digit blanking and a frame-done pulse.
- Sits between the value/formatting logic and the segment decoder and anode drivers.

Parameters:
- DIGITS, 4: number of digit fields and select lines; legal range is 2 or more.
- DW, 4: width of each digit field in bits.
- DIV, 100000: slot length in clock cycles; must satisfy DIV > GUARD + 1.
- GUARD, 16: cycles at the start of each slot during which all selects are forced off.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- data  in  DIGITS*DW  packed digits; field k is data[k*DW +: DW], so field 0 is the LSBs.
- blank_mask  in  DIGITS  a 1 in bit k blanks digit k.
- sel  out  DIGITS  one-hot digit select, active-high; all-zero means none selected.
- digit  out  DW  field value for the active slot.
- digit_idx  out  $clog2(DIGITS)  index of the current slot.
- frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Internal state:
  - cnt is a counter running 0..DIV-1.
  - idx is a counter running 0..DIGITS-1.
  - snap_data and snap_mask are the snapshot registers.
- All outputs are registered. The outputs at cycle t+1 are a function of cnt, idx and the snapshot at cycle t.
- Reset (rst=1, which takes priority over everything):
  - cnt=0, idx=0, snap_data=0, snap_mask=0.
  - sel=0, digit=0, digit_idx=0, frame_done=0.
  - Reset applied mid-scan aborts the current slot immediately; no partial-frame pulse is issued.
- en=0 (idle):
  - cnt=0 and idx=0.
  - sel=0, digit=0, frame_done=0.
  - snap_data<=data and snap_mask<=blank_mask every cycle, so the first frame after enable uses current inputs.
- en=1 (scanning):
  - If cnt==DIV-1: cnt<=0 and idx<=(idx==DIGITS-1 ? 0 : idx+1). Otherwise cnt<=cnt+1.
  - Wrap event: cnt==DIV-1 and idx==DIGITS-1. On a wrap:
    - snap_data<=data and snap_mask<=blank_mask.
    - frame_done<=1 for exactly one cycle.
  - Inputs are sampled only at a wrap, so mid-frame changes to data or blank_mask never tear the display.
- Output decode, registered from the pre-update values of cnt, idx and the snapshot:
  - digit_idx<=idx.
  - digit<=snap_data field idx, or 0 if snap_mask[idx]=1.
  - sel<=0 if cnt<GUARD or snap_mask[idx]=1; otherwise sel<=(1<<idx).
- Invariants:
  - At most one bit of sel is set at any time.
  - sel never switches directly from one nonzero value to a different nonzero value; at least GUARD zero cycles separate them.
  - Each digit is active for DIV-GUARD cycles per frame.
  - A frame is DIGITS*DIV cycles.
- en falling mid-slot:
  - cnt and idx go to 0 the next cycle, and sel goes to 0 the cycle after that.
  - When en rises again, scanning starts from slot 0 with a full guard interval.
- Width rules:
  - cnt is $clog2(DIV) bits wide; idx is $clog2(DIGITS) bits wide.
  - Wrap-around is by explicit compare, not by natural overflow, so non-power-of-2 DIGITS and DIV are legal.

Decomposition:
- Shared display package holds:
  - the one-hot decode function onehot(idx, DIGITS);
  - the default constants DIV and GUARD for the 100 MHz board clock.
- Sub-module scan_prescaler(DIV):
  - Inputs are clk, rst and en.
  - Outputs are cnt and tick, where tick = (cnt==DIV-1).
  - It clears to 0 when en=0.
  - The top level holds idx, the snapshot registers and the output decode.

Test Plan:
Configuration for all scenarios: DIGITS=4, DW=4, DIV=8, GUARD=2.
- Reset check: hold rst for 3 cycles with en=1 and data=16'hFFFF -> sel=0, digit=0, frame_done=0 throughout; the first sel after rst drops is 4'b0001, which appears 3 cycles after the first clock edge with rst=0 (guard plus register stage).
- Scan order: apply en=1, data=16'hA5C3, mask=0 -> digit sequence 3, C, 5, A; sel sequence 0001, 0010, 0100, 1000; each sel is high for 6 cycles and each guard gap is 2 zero cycles; frame_done pulses once every 32 cycles.
- Tear-free update: change data to 16'h1234 at cycle 10 of a frame -> the remaining slots still show 5 and A; the next frame shows 4, 3, 2, 1.
- Blanking: apply mask=4'b0100 -> during slot 2, sel=0 and digit=0; the other slots are unaffected; the slot timing is unchanged.
- Enable toggle: drop en during slot 2, then raise it 5 cycles later -> sel=0 while disabled; on resume, slot 0 starts with a 2-cycle guard and uses the data present while disabled.
- Mid-scan reset: assert rst for 1 cycle during slot 3 -> all outputs are 0 on the next cycle with no frame_done pulse; the scan restarts at slot 0 using the post-reset snapshot.

Source files
------------

// File: rtl/digit_scan_mux_pkg.sv
// Shared display definitions: board-clock timing defaults and the one-hot
// select decode used by the digit scanner.
package digit_scan_mux_pkg;

  // Slot length for the 100 MHz board clock: 100000 cycles = 1 ms per digit.
  localparam int DEFAULT_DIV   = 100000;
  // Dead time at the start of each slot so the previous anode fully turns off.
  localparam int DEFAULT_GUARD = 16;

  // Widest select vector the decode helper can produce.
  localparam int ONEHOT_W = 32;

  // One-hot decode of idx over a select vector of 'digits' lines; an index
  // outside the vector gives all-zero (nothing selected).
  function automatic logic [ONEHOT_W-1:0] onehot(input int idx, input int digits);
    if (idx >= 0 && idx < digits && idx < ONEHOT_W) onehot = ONEHOT_W'(1) << idx;
    else                                            onehot = '0;
  endfunction

endpackage

// File: rtl/digit_scan_mux_if.sv
// Bus between the value/formatting logic (master) and the digit scanner
// (slave): packed digit word and blanking in, select/digit/frame pulse out.
interface digit_scan_mux_if #(
  parameter int DIGITS = 4,
  parameter int DW     = 4
);

  logic                        en;
  logic [DIGITS*DW-1:0]        data;
  logic [DIGITS-1:0]           blank_mask;
  logic [DIGITS-1:0]           sel;
  logic [DW-1:0]               digit;
  logic [$clog2(DIGITS)-1:0]   digit_idx;
  logic                        frame_done;

  modport master (
    output en, data, blank_mask,
    input  sel, digit, digit_idx, frame_done
  );

  modport slave (
    input  en, data, blank_mask,
    output sel, digit, digit_idx, frame_done
  );

endinterface

// File: rtl/digit_scan_mux_scan_prescaler.sv
// Slot-rate prescaler: counts 0..DIV-1 while enabled and flags the last
// cycle of each slot. Held at zero while disabled.
module scan_prescaler
  import digit_scan_mux_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV,
  parameter int CW  = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tick
);

  // Explicit terminal compare so non-power-of-2 slot lengths wrap correctly.
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

  // Slot cycle counter: clear on reset or disable, wrap at DIV-1.
  // NOTE: registers are written with non-blocking '<=' so every flop in the design samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !en)           cnt <= '0;
    else if (cnt == LAST_CNT) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST_CNT);

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed digit scanner. Snapshots the packed digit word at each
// frame wrap (or continuously while idle), steps a one-hot select across the
// digits once per slot with a guard interval at the start of every slot, and
// presents the selected field on the shared digit bus. All outputs are
// registered from the pre-edge slot position and snapshot.
module digit_scan_mux
  import digit_scan_mux_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DW     = 4,
  parameter int DIV    = DEFAULT_DIV,
  parameter int GUARD  = DEFAULT_GUARD
) (
  input  logic            clk,
  input  logic            rst,
  digit_scan_mux_if.slave io
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);

  localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
  localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);

  logic [CW-1:0]        cnt;
  logic                 tick;
  logic [IW-1:0]        idx;
  logic                 run;
  logic [DIGITS*DW-1:0] snap_data;
  logic [DIGITS-1:0]    snap_mask;
  logic                 wrap;
  logic                 in_guard;
  logic [DW-1:0]        field;

  scan_prescaler #(
    .DIV (DIV),
    .CW  (CW)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (io.en),
    .cnt  (cnt),
    .tick (tick)
  );

  // Frame wrap, guard window and the field addressed by the current slot.
  // NOTE: combinational logic uses blocking '=' and assigns every signal on every path, so no latch is inferred.
  always_comb begin
    wrap     = tick && (idx == LAST_IDX);
    in_guard = (cnt < GUARD_CNT);
    field    = DW'(snap_data >> (idx * DW));
  end

  // Slot index, snapshot capture and the scan-active flag. 'run' remembers
  // whether the previous cycle was scanning, so the outputs lag a falling
  // enable by one cycle like every other registered decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      run       <= 1'b0;
      snap_data <= '0;
      snap_mask <= '0;
    end else if (!io.en) begin
      idx       <= '0;
      run       <= 1'b0;
      snap_data <= io.data;
      snap_mask <= io.blank_mask;
    end else begin
      run <= 1'b1;
      if (tick) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      // Inputs are taken only at the frame boundary so a frame never tears.
      if (wrap) begin
        snap_data <= io.data;
        snap_mask <= io.blank_mask;
      end
    end
  end

  // Registered output decode from the pre-edge slot position and snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      io.sel        <= '0;
      io.digit      <= '0;
      io.digit_idx  <= '0;
      io.frame_done <= 1'b0;
    end else begin
      io.digit_idx  <= idx;
      io.frame_done <= io.en && wrap;
      if (run && !snap_mask[idx]) begin
        io.digit <= field;
        io.sel   <= in_guard ? '0 : DIGITS'(onehot(int'(idx), DIGITS));
      end else begin
        io.digit <= '0;
        io.sel   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Bench for digit_scan_mux (DIGITS=4, DW=4, DIV=8, GUARD=2). A position-in-
// frame model predicts every output each cycle; directed frames pin scan
// order, tear-free updates, blanking, enable toggling and mid-scan reset, and
// a randomized phase exercises arbitrary enable/data/mask/reset sequences.
module tb_digit_scan_mux;

  localparam int DIGITS = 4;
  localparam int DW     = 4;
  localparam int DIV    = 8;
  localparam int GUARD  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  digit_scan_mux_if #(.DIGITS(DIGITS), .DW(DW)) io ();

  digit_scan_mux #(
    .DIGITS (DIGITS),
    .DW     (DW),
    .DIV    (DIV),
    .GUARD  (GUARD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the scan position is one number 0..FRAME-1; slot and
  // offset fall out of division by the slot length.
  int          m_pos;
  bit          m_run;
  logic [15:0] m_data;
  logic [3:0]  m_mask;
  logic [3:0]  e_sel;
  logic [3:0]  e_digit;
  logic [1:0]  e_idx;
  logic        e_fd;
  bit          started = 0;

  always @(posedge clk) begin : model
    int slot;
    int off;
    slot = m_pos / DIV;
    off  = m_pos % DIV;
    if (rst) begin
      m_pos = 0; m_run = 0; m_data = '0; m_mask = '0;
      e_sel = '0; e_digit = '0; e_idx = '0; e_fd = 1'b0;
    end else begin
      e_idx = 2'(slot);
      e_fd  = io.en && (m_pos == FRAME - 1);
      if (m_run && !m_mask[slot]) begin
        e_digit = 4'(m_data >> (DW * slot));
        e_sel   = (off >= GUARD) ? 4'(1 << slot) : 4'b0000;
      end else begin
        e_digit = '0;
        e_sel   = '0;
      end
      if (!io.en) begin
        m_pos  = 0;
        m_data = io.data;
        m_mask = io.blank_mask;
      end else begin
        if (m_pos == FRAME - 1) begin
          m_data = io.data;
          m_mask = io.blank_mask;
        end
        m_pos = (m_pos + 1) % FRAME;
      end
      m_run = io.en;
    end
    started = 1;
  end

  // Per-cycle compare against the model plus the select-line invariants.
  logic [3:0] last_nz = '0;
  int         zeros   = 0;

  always @(negedge clk) begin
    if (started) begin
      check("sel", io.sel, e_sel);
      check("digit", io.digit, e_digit);
      check("digit_idx", io.digit_idx, e_idx);
      check("frame_done", io.frame_done, e_fd);
      check("sel_at_most_one", ($countones(io.sel) <= 1), 1);
      if (io.sel != 4'b0000) begin
        if (last_nz != 4'b0000 && io.sel != last_nz) check("guard_gap", (zeros >= GUARD), 1);
        last_nz = io.sel;
        zeros   = 0;
      end else begin
        zeros++;
      end
    end
  end

  // Directed helpers.
  logic [3:0] cap_sel [FRAME];
  logic [3:0] cap_dig [FRAME];
  logic       cap_fd  [FRAME];

  task automatic first_sel(input int exp_n, input logic [3:0] exp_sel, input logic [3:0] exp_digit);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (io.sel !== 4'b0000) begin
        n = i;
        break;
      end
    end
    check("first_sel_latency", n, exp_n);
    check("first_sel_value", io.sel, exp_sel);
    check("first_sel_digit", io.digit, exp_digit);
  endtask

  // Records one frame of outputs; optionally syncs to a frame_done first and
  // optionally changes the data word mid-frame.
  task automatic capture_frame(input bit sync, input int change_at, input logic [15:0] new_data);
    bit ok;
    ok = 0;
    if (sync) begin
      for (int i = 0; i < 3 * FRAME; i++) begin
        @(negedge clk);
        if (io.frame_done === 1'b1) begin
          ok = 1;
          break;
        end
      end
      if (!ok) check("frame_done_timeout", 0, 1);
    end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      cap_sel[k] = io.sel;
      cap_dig[k] = io.digit;
      cap_fd[k]  = io.frame_done;
      if (k == change_at) io.data = new_data;
    end
  endtask

  task automatic check_frame(input logic [15:0] exp_data, input logic [3:0] exp_mask);
    int fds;
    fds = 0;
    for (int s = 0; s < DIGITS; s++) begin
      int on;
      on = 0;
      for (int off = 0; off < DIV; off++) begin
        int k;
        logic [3:0] es;
        k  = s * DIV + off;
        es = (!exp_mask[s] && off >= GUARD) ? 4'(1 << s) : 4'b0000;
        if (cap_sel[k] !== 4'b0000) on++;
        if (cap_fd[k] === 1'b1) fds++;
        check("frame_sel", cap_sel[k], es);
        check("frame_digit", cap_dig[k], exp_mask[s] ? 4'h0 : 4'(exp_data >> (DW * s)));
      end
      check("slot_active_cycles", on, exp_mask[s] ? 0 : DIV - GUARD);
    end
    check("frame_done_count", fds, 1);
    check("frame_done_at_end", cap_fd[FRAME-1], 1);
  endtask

  initial begin : main
    bit found;

    // Reset held with scanning requested: everything stays quiet.
    rst = 1'b1; io.en = 1'b1; io.data = 16'hFFFF; io.blank_mask = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      check("reset_sel", io.sel, 4'b0000);
      check("reset_digit", io.digit, 4'h0);
      check("reset_frame_done", io.frame_done, 1'b0);
    end
    io.data = 16'hA5C3;
    rst     = 1'b0;
    // Guard plus register stage; snapshot is still the reset value of zero.
    first_sel(3, 4'b0001, 4'h0);

    // Scan order and slot timing.
    capture_frame(1, -1, 16'h0000);
    check_frame(16'hA5C3, 4'b0000);

    // Data changes at cycle 10 of a frame only show up in the next frame.
    capture_frame(0, 10, 16'h1234);
    check_frame(16'hA5C3, 4'b0000);
    capture_frame(0, -1, 16'h0000);
    check_frame(16'h1234, 4'b0000);

    // Blanking of digit 2, taken at the next wrap and released one frame later.
    io.blank_mask = 4'b0100;
    capture_frame(0, -1, 16'h0000);
    check_frame(16'h1234, 4'b0000);
    io.blank_mask = 4'b0000;
    capture_frame(0, -1, 16'h0000);
    check_frame(16'h1234, 4'b0100);

    // Enable dropped in the middle of slot 2's active window.
    for (int k = 0; k < 20; k++) @(negedge clk);
    io.en   = 1'b0;
    io.data = 16'h9876;
    @(negedge clk);
    check("en_fall_lag_sel", io.sel, 4'b0100);
    check("en_fall_lag_digit", io.digit, 4'h2);
    for (int n = 2; n <= 5; n++) begin
      @(negedge clk);
      check("disabled_sel", io.sel, 4'b0000);
      check("disabled_digit", io.digit, 4'h0);
    end
    io.en = 1'b1;
    first_sel(3, 4'b0001, 4'h6);

    // One-cycle reset during slot 3.
    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (io.sel === 4'b1000) begin
        found = 1;
        break;
      end
    end
    check("reach_slot3", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_sel", io.sel, 4'b0000);
    check("midreset_digit", io.digit, 4'h0);
    check("midreset_idx", io.digit_idx, 2'd0);
    check("midreset_frame_done", io.frame_done, 1'b0);
    rst = 1'b0;
    first_sel(3, 4'b0001, 4'h0);

    // Randomized enable, data, mask and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) io.en = ~io.en;
      if ($urandom_range(0, 19) == 0) io.data = 16'($urandom);
      if ($urandom_range(0, 29) == 0)
        io.blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
    end
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
